// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI link constants and responder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  // Link mode shared with the master: clock idles high, sample on falling edge.
  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : N-stage synchroniser with single-clk rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = CPOL
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign q    = r_sync[STAGES-1];
  assign rise = ~r_prev & q;
  assign fall = r_prev & ~q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : CPOL=1/CPHA=0 SPI responder receiver, oversampled on clk,
//               with a valid/ready holding register for received words.
//               Define SPI_SLAVE_MISO_EN to build the MISO transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int c_CNT_W    = $clog2(DATA_W + 1);
  localparam int c_SETTLE_W = 3;

  spi_state_t r_state;
  spi_state_t w_state_next;

  logic                   w_sclk_q;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_q;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  logic [DATA_W-1:0]      r_shift;
  logic [c_CNT_W-1:0]     r_bit_cnt;
  logic                   r_load;
  logic [c_SETTLE_W-1:0]  r_settle;
  logic                   w_settled;
  logic                   r_armed;

  logic                   w_start;
  logic                   w_sample;
  logic                   w_last;
  logic                   w_abort;

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (CPOL)
  ) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .d     (spi_clk),
    .q     (w_sclk_q),
    .rise  (w_sclk_rise),
    .fall  (w_sclk_fall)
  );

  spi_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .d     (cs_n),
    .q     (w_cs_q),
    .rise  (w_cs_rise),
    .fall  (w_cs_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // The cs_n synchroniser resets high, so its output is only trusted once the
  // chain has refilled; a frame interrupted by reset is then skipped until
  // cs_n is genuinely seen high.
  assign w_settled = (r_settle == c_SETTLE_W'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (!w_settled) begin
        r_settle <= r_settle + c_SETTLE_W'(1);
      end
      if (w_settled && w_cs_q) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_sample     = 1'b0;
    w_last       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_armed && !w_cs_q) begin
          w_start      = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_q) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end else if (w_sclk_fall) begin
          w_sample = 1'b1;
          if (r_bit_cnt == c_CNT_W'(DATA_W - 1)) begin
            w_last       = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        if (w_cs_q) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_load     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_load     <= w_last;
      rx_overrun <= 1'b0;
      frame_err  <= w_abort;
      if (w_start) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_shift   <= {r_shift[DATA_W-2:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
      end
      // A word landing together with an accept replaces the old one cleanly.
      if (r_load) begin
        rx_data    <= r_shift;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state == SHIFT);

`ifdef SPI_SLAVE_MISO_EN
  logic [DATA_W-1:0] r_tx_shift;
  logic              w_unused_mode;

  // Next bit goes out on the rise so it is stable at the master's fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_shift <= '1;
    end else if (w_start) begin
      r_tx_shift <= tx_data;
    end else if (busy && w_sclk_rise) begin
      r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b1};
    end
  end

  assign miso          = busy ? r_tx_shift[DATA_W-1] : 1'b1;
  assign w_unused_mode = ^{w_sclk_q, w_cs_rise, w_cs_fall};
`else
  logic w_unused_mode;

  assign miso          = 1'b1;
  assign w_unused_mode = ^{w_sclk_q, w_sclk_rise, w_cs_rise, w_cs_fall, tx_data};
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_rx
// Description : Directed self-checking bench for spi_slave_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_clk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ovr_cnt  = 0;
  int fe_cnt   = 0;
  int t_last_fall  = 0;
  int t_valid_rise = -1;
  logic prev_valid = 1'b0;
  logic [7:0] cap;
  logic [7:0] miso_exp;

  spi_slave_rx #(
    .DATA_W      (8),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_overrun) ovr_cnt++;
    if (frame_err) fe_cnt++;
    if (rx_valid && !prev_valid) t_valid_rise = cyc;
    prev_valid = rx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side: 4 clk per spi_clk phase; rst_after_bit > 0 pulses reset then.
  task automatic spi_frame(input logic [7:0] d, input int nbits, input bit ready_at_land,
                           input int rst_after_bit, output logic [7:0] miso_cap);
    miso_cap = 8'hFF;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = d[7];
    wait_clks(8);
    for (int i = 0; i < nbits; i++) begin
      miso_cap[7-i] = miso;
      spi_clk = 1'b0;
      t_last_fall = cyc;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (ready_at_land && i == nbits - 1 && j == 2) rx_ready = 1'b1;
        if (ready_at_land && i == nbits - 1 && j == 3) rx_ready = 1'b0;
      end
      if (rst_after_bit == i + 1) begin
        check_eq("busy_mid_frame", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("busy_after_reset", busy, 1'b0);
        check_eq("valid_after_reset", rx_valid, 1'b0);
      end
      spi_clk = 1'b1;
      if (i < 7) mosi = d[6-i];
      wait_clks(4);
    end
    cs_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    spi_clk  = 1'b1;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    rx_ready = 1'b0;
    tx_data  = 8'h00;
    wait_clks(3);
    check_eq("rst_rx_valid", rx_valid, 1'b0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_miso", miso, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overrun", rx_overrun, 1'b0);
    check_eq("rst_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    wait_clks(6);

    // Single frame
    ovr_cnt = 0; fe_cnt = 0; t_valid_rise = -1;
    spi_frame(8'hA5, 8, 1'b0, 0, cap);
    check_eq("a5_data", rx_data, 8'hA5);
    check_eq("a5_valid", rx_valid, 1'b1);
    check_eq("a5_latency", t_valid_rise - t_last_fall, SYNC + 2);
    check_eq("a5_overrun", ovr_cnt, 0);
    check_eq("a5_frame_err", fe_cnt, 0);
    check_eq("idle_miso", miso, 1'b1);
    check_eq("idle_busy", busy, 1'b0);
    consume();
    check_eq("a5_consumed", rx_valid, 1'b0);

    // Back-to-back with no consumer
    ovr_cnt = 0;
    spi_frame(8'h3C, 8, 1'b0, 0, cap);
    check_eq("3c_data", rx_data, 8'h3C);
    spi_frame(8'hC3, 8, 1'b0, 0, cap);
    check_eq("c3_data", rx_data, 8'hC3);
    check_eq("c3_valid", rx_valid, 1'b1);
    check_eq("c3_overrun_cnt", ovr_cnt, 1);

    // Accept in the landing cycle
    ovr_cnt = 0;
    spi_frame(8'h69, 8, 1'b1, 0, cap);
    check_eq("coll_data", rx_data, 8'h69);
    check_eq("coll_valid", rx_valid, 1'b1);
    check_eq("coll_overrun", ovr_cnt, 0);
    consume();
    check_eq("coll_consumed", rx_valid, 1'b0);

    // Abort after 5 bits
    fe_cnt = 0;
    spi_frame(8'hFF, 5, 1'b0, 0, cap);
    check_eq("abort_fe_cnt", fe_cnt, 1);
    check_eq("abort_valid", rx_valid, 1'b0);
    check_eq("abort_data", rx_data, 8'h69);
    spi_frame(8'h12, 8, 1'b0, 0, cap);
    check_eq("12_data", rx_data, 8'h12);
    check_eq("12_valid", rx_valid, 1'b1);
    check_eq("12_fe_cnt", fe_cnt, 1);
    consume();

    // Reset after bit 3 with cs_n held low
    fe_cnt = 0;
    spi_frame(8'hE7, 8, 1'b0, 3, cap);
    check_eq("rstmid_valid", rx_valid, 1'b0);
    check_eq("rstmid_data", rx_data, 8'h00);
    check_eq("rstmid_fe", fe_cnt, 0);
    spi_frame(8'h81, 8, 1'b0, 0, cap);
    check_eq("81_data", rx_data, 8'h81);
    check_eq("81_valid", rx_valid, 1'b1);
    consume();

    // MISO return path
    tx_data = 8'h5A;
`ifdef SPI_SLAVE_MISO_EN
    miso_exp = 8'h5A;
`else
    miso_exp = 8'hFF;
`endif
    spi_frame(8'h0F, 8, 1'b0, 0, cap);
    check_eq("miso_capture", cap, miso_exp);
    check_eq("0f_data", rx_data, 8'h0F);
    check_eq("miso_idle_after", miso, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
